// File: rtl/reset_pulse_gen_if.sv
// Command / protocol-line bundle for the reset_n pulse transmitter.
// The master side issues commands; the slave side is the transmitter itself.
interface reset_pulse_gen_if;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic       cmd_ready;
    logic       reset_n_out;
    logic       busy;
    logic       done;
    logic       cmd_err;

    modport master (
        output cmd_valid, cmd_type,
        input  cmd_ready, reset_n_out, busy, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_type,
        output cmd_ready, reset_n_out, busy, done, cmd_err
    );
endinterface

// File: rtl/reset_pulse_gen.sv
// Controller-side transmitter for the single-wire reset_n command protocol.
// Holds reset_n low for a commanded number of clk periods (the chip decodes the
// action from the low duration), then enforces a high gap before the next one.
module reset_pulse_gen #(
    parameter int TS_LOW_CYCLES  = 8,
    parameter int RST_LOW_CYCLES = 24,
    parameter int CFG_LOW_CYCLES = 48,
    parameter int GAP_CYCLES     = 40,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    reset_pulse_gen_if.slave  bus
);

    // Reject durations the chip-side receiver would decode ambiguously, and
    // counts that would not fit the down-counter.
    if (TS_LOW_CYCLES < 5 || TS_LOW_CYCLES > 15 ||
        RST_LOW_CYCLES < 17 || RST_LOW_CYCLES > 31 ||
        CFG_LOW_CYCLES < 33 || CFG_LOW_CYCLES > 255 ||
        GAP_CYCLES < 33 || GAP_CYCLES > 255 ||
        !(TS_LOW_CYCLES < RST_LOW_CYCLES && RST_LOW_CYCLES < CFG_LOW_CYCLES) ||
        CFG_LOW_CYCLES > (1 << CNT_W) || GAP_CYCLES > (1 << CNT_W)) begin : g_bad_params
        $error("reset_pulse_gen: illegal duration parameters");
    end

    localparam logic [CNT_W-1:0] TS_LOAD  = CNT_W'(TS_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CFG_LOAD = CNT_W'(CFG_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] load_d;
    logic             line_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Select the low-duration reload for the command currently offered.
    always_comb begin
        // NOTE: default first so every path assigns load_d and no latch is inferred.
        load_d = TS_LOAD;
        case (bus.cmd_type)
            2'd1:    load_d = RST_LOAD;
            2'd2:    load_d = CFG_LOAD;
            default: load_d = TS_LOAD;
        endcase
    end

    // Pulse FSM: IDLE accepts, LOW drives the line, GAP enforces high time.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: async reset clears every flop so a mid-pulse reset releases the line immediately.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so all flops update from pre-edge values.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_type == 2'd3) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= S_LOW;
                            cnt_q   <= load_d;
                            line_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    if (cnt_q == '0) begin
                        state_q <= S_GAP;
                        cnt_q   <= GAP_LOAD;
                        line_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    line_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is purely a function of state; everything else leaves on a flop.
    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.reset_n_out = line_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Bench for reset_pulse_gen: a timeline model (pulse start edge + durations)
// is compared against the DUT on every negedge, plus directed scenarios with
// hand-computed expectations and a duration-decoding receiver model.
module tb_reset_pulse_gen;

    localparam int N_TS  = 8;
    localparam int N_RST = 24;
    localparam int N_CFG = 48;
    localparam int G     = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    reset_pulse_gen_if bus();

    reset_pulse_gen #(
        .TS_LOW_CYCLES (N_TS),
        .RST_LOW_CYCLES(N_RST),
        .CFG_LOW_CYCLES(N_CFG),
        .GAP_CYCLES    (G),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Period c is the interval after the c-th posedge since start.
    int cyc      = 0;
    int p_start  = -100000;
    int p_len    = 0;
    int err_edge = -100000;

    function automatic bit m_busy(input int c);
        return (c >= p_start) && (c < p_start + p_len + G);
    endfunction

    function automatic int dur_of(input logic [1:0] t);
        return (t == 2'd0) ? N_TS : (t == 2'd1) ? N_RST : N_CFG;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p_start  = -100000;
            p_len    = 0;
            err_edge = -100000;
        end else begin
            if (!m_busy(cyc) && bus.cmd_valid === 1'b1) begin
                if (bus.cmd_type == 2'd3) begin
                    err_edge = cyc + 1;
                end else begin
                    p_start = cyc + 1;
                    p_len   = dur_of(bus.cmd_type);
                end
            end
            cyc++;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (reset) begin
                check("rst_line",  int'(bus.reset_n_out), 1);
                check("rst_busy",  int'(bus.busy),        0);
                check("rst_done",  int'(bus.done),        0);
                check("rst_err",   int'(bus.cmd_err),     0);
                check("rst_ready", int'(bus.cmd_ready),   1);
            end else begin
                check("line",  int'(bus.reset_n_out),
                      ((cyc >= p_start) && (cyc < p_start + p_len)) ? 0 : 1);
                check("busy",  int'(bus.busy),      int'(m_busy(cyc)));
                check("done",  int'(bus.done),      int'(cyc == p_start + p_len + G));
                check("err",   int'(bus.cmd_err),   int'(cyc == err_edge));
                check("ready", int'(bus.cmd_ready), int'(!m_busy(cyc)));
            end
        end
    end

    // ---------------- receiver model ----------------
    int lo_cnt = 0, hi_cnt = 0, last_lo = 0, last_hi = 0, rx_pulses = 0;

    always @(negedge clk) begin
        if (bus.reset_n_out === 1'b0) begin
            if (hi_cnt > 0) begin
                last_hi = hi_cnt;
                hi_cnt  = 0;
            end
            lo_cnt++;
        end else begin
            if (lo_cnt > 0) begin
                last_lo = lo_cnt;
                lo_cnt  = 0;
                rx_pulses++;
            end
            hi_cnt++;
        end
    end

    // Stimulus slot: 2 ns after negedge, well clear of both edges.
    task automatic slot();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] t);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            slot();
            if (bus.cmd_ready) ok = 1'b1;
        end
        if (!ok) check("send_wait_ready", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input string name);
        int n = 0;
        while (rx_pulses < target && n < 300) begin
            slot();
            n++;
        end
        if (rx_pulses < target) check(name, rx_pulses, target);
    endtask

    initial begin
        int lo_n, first_lo, busy_n, done_off, ready_off, err_n, p0, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'd0;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        slot();
        check("reset_line",  int'(bus.reset_n_out), 1);
        check("reset_ready", int'(bus.cmd_ready),   1);
        reset = 1'b0;

        // Type 0: measure pulse, busy window and done relative to accept edge.
        send(2'd0);
        lo_n = 0; first_lo = -1; busy_n = 0; done_off = -1; ready_off = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (!bus.reset_n_out) begin
                lo_n++;
                if (first_lo < 0) first_lo = i;
            end
            if (bus.busy) busy_n++;
            if (bus.done && done_off < 0) done_off = i;
            if (bus.cmd_ready && ready_off < 0) ready_off = i;
        end
        check("ts_low_len",    lo_n,      8);
        check("ts_low_start",  first_lo,  0);
        check("ts_busy_len",   busy_n,    48);
        check("ts_done_off",   done_off,  48);
        check("ts_ready_off",  ready_off, 48);

        // Type 2: receiver decodes config + internal + timestamp.
        p0 = rx_pulses;
        send(2'd2);
        wait_pulses(p0 + 1, "cfg_pulse_seen");
        check("cfg_low_len", last_lo, 48);
        check("cfg_rx_cfg",  int'(last_lo >= 32), 1);
        check("cfg_rx_rst",  int'(last_lo >= 16), 1);
        check("cfg_rx_ts",   int'(last_lo >= 4),  1);

        // Back-to-back with valid held: type 1 then type 0.
        p0 = rx_pulses;
        n  = 0;
        while (!bus.cmd_ready && n < 200) begin slot(); n++; end
        slot();
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'd1;
        @(posedge clk);
        #1;
        bus.cmd_type  = 2'd0;
        wait_pulses(p0 + 1, "b2b_first_seen");
        n = 0;
        while (bus.reset_n_out && n < 200) begin slot(); n++; end
        bus.cmd_valid = 1'b0;
        check("b2b_first_len", last_lo, 24);
        check("b2b_gap_len",   last_hi, 41);
        wait_pulses(p0 + 2, "b2b_second_seen");
        check("b2b_second_len", last_lo, 8);
        check("b2b_rx_rst",    int'(last_lo >= 16), 0);
        check("b2b_rx_ts",     int'(last_lo >= 4),  1);

        // Reserved type: one-cycle error, no pulse.
        send(2'd3);
        lo_n = 0; busy_n = 0; err_n = 0; ready_off = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (!bus.reset_n_out) lo_n++;
            if (bus.busy) busy_n++;
            if (bus.cmd_err) err_n++;
            if (bus.cmd_ready) ready_off++;
        end
        check("err_pulses",  err_n,     1);
        check("err_no_low",  lo_n,      0);
        check("err_no_busy", busy_n,    0);
        check("err_ready",   ready_off, 6);

        // Changing cmd_type during LOW does not alter the duration.
        p0 = rx_pulses;
        send(2'd0);
        slot();
        bus.cmd_type = 2'd2;
        wait_pulses(p0 + 1, "chg_pulse_seen");
        check("chg_low_len", last_lo, 8);

        // Reset mid config pulse: line releases before the next edge.
        send(2'd2);
        repeat (10) slot();
        check("mid_line_low", int'(bus.reset_n_out), 0);
        reset = 1'b1;
        #1;
        check("async_line", int'(bus.reset_n_out), 1);
        check("async_busy", int'(bus.busy),        0);
        check("async_ready", int'(bus.cmd_ready),  1);
        slot();
        reset = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'd0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_accept", int'(bus.reset_n_out), 0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            slot();
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                reset = 1'b1;
            end
            bus.cmd_valid = ($urandom_range(2) == 0);
            bus.cmd_type  = 2'($urandom_range(3));
        end
        slot();
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (100) slot();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_pulse_gen.md
Name: reset_pulse_gen

Overview:
- Controller-side transmitter for the single-wire reset_n command protocol.
- Drives the chip's reset_n line low for a commanded number of clk cycles to request one of three actions: timestamp sync, internal reset, or config-register reset.
- The chip-side receiver decodes the action by duration: ≥4 cycles low gives timestamp sync, ≥16 gives internal reset, ≥32 gives config reset.
- Block sits in the test/controller fabric on the same clk as the chip and accepts commands via a valid/ready handshake.

Parameters:
- TS_LOW_CYCLES, 8, low duration for timestamp sync (must be in 5..15).
- RST_LOW_CYCLES, 24, low duration for internal reset (must be in 17..31).
- CFG_LOW_CYCLES, 48, low duration for config reset (must be in 33..255).
- GAP_CYCLES, 40, minimum high time after each pulse before the next command is accepted (must be in 33..255).
- CNT_W, 8, width of the duration counter.

Ports:
- clk  input  1  master clock; all logic on posedge.
- reset  input  1  asynchronous, active-high block reset.
- cmd_valid  input  1  command request.
- cmd_type  input  2  0 = timestamp sync, 1 = internal reset, 2 = config reset, 3 = reserved.
- cmd_ready  output  1  high when a command can be accepted.
- reset_n_out  output  1  registered protocol line to the chip; idle high.
- busy  output  1  high while in LOW or GAP.
- done  output  1  one-cycle pulse when GAP completes.
- cmd_err  output  1  one-cycle pulse when a reserved command is accepted.

Behaviour:
- Reset: asynchronous, active-high.
  - All state is cleared immediately on assertion, independent of clk.
  - Reset values: reset_n_out=1, busy=0, done=0, cmd_err=0, state=IDLE, counter=0.
  - cmd_ready=1 is combinational from state.
  - Reset mid-pulse ends the pulse at once (line returns high). No gap is enforced after reset release.
- FSM states: IDLE, LOW, GAP.
- IDLE:
  - cmd_ready=1.
  - Accept occurs at a posedge with cmd_valid=1.
  - Type 0/1/2: go to LOW, set reset_n_out<=0, load the counter with the matching *_LOW_CYCLES−1.
  - Type 3: stay in IDLE, reset_n_out stays 1, cmd_err=1 for the next cycle only.
- LOW:
  - reset_n_out=0, cmd_ready=0, busy=1.
  - Counter decrements each cycle.
  - At the edge where the counter equals 0: reset_n_out<=1, go to GAP, load GAP_CYCLES−1.
  - Result: the line is low for exactly N posedge-to-posedge periods, starting the cycle after accept.
- GAP:
  - reset_n_out=1, cmd_ready=0, busy=1.
  - Counter decrements. At 0: go to IDLE, done=1 for one cycle.
  - A new command can be accepted on the first IDLE edge, so the line is high for at least GAP_CYCLES+1 periods between pulses.
- Handshake rules:
  - cmd_type is sampled only at the accept edge; changes during LOW/GAP are ignored.
  - cmd_valid held while not ready is not lost; it is accepted on return to IDLE.
- Output timing:
  - reset_n_out is driven by a flop on posedge clk, with no combinational path from inputs.
  - The chip samples on negedge, giving a half-cycle setup margin.
- Counter: CNT_W bits, down-counting; no wrap occurs with legal parameters.
  - Parameter checks (elaboration assertion): values within the stated ranges, and TS < RST < CFG.
- Simultaneous events: reset overrides everything. done and a new accept cannot coincide (done is asserted on the IDLE entry cycle; accept is evaluated on the following edges).

Test Plan:
- After reset release, cmd_valid=1 with cmd_type=0 at edge k → reset_n_out low on exactly cycles k+1..k+8, high at k+9. busy high k+1..k+48; done pulse at k+49; cmd_ready returns at k+49.
- Command with cmd_type=2 → low for exactly 48 cycles; a receiver model reports config reset, internal reset and timestamp sync all asserted, then all deasserted after the line returns high.
- Back-to-back: type 1 then type 0 with cmd_valid held → second pulse starts exactly 41 edges after the first pulse ends. The 8-cycle second pulse triggers only timestamp sync in the receiver model.
- cmd_type=3 → reset_n_out stays 1, cmd_err high exactly one cycle, cmd_ready stays 1, busy stays 0.
- Assert reset at cycle 10 of a 48-cycle config pulse → reset_n_out goes high asynchronously before the next edge. State is IDLE, and a new command is accepted on the first edge after reset release.
- Change cmd_type from 0 to 2 during LOW → pulse length stays 8 cycles.
